// File: rtl/stream_arb_pkg.sv
// Shared types and defaults for the two-input stream arbiter.
package stream_arb_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/stream_arb2to1_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, and contention goes to the
// side opposite the last grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = ~last;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last;
        endcase
    end

endmodule

// File: rtl/stream_arb2to1.sv
// 2:1 stream arbiter with a single registered output slot; readies are
// combinational so a full slot can be refilled in the cycle it drains.
module stream_arb2to1
    import stream_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             last_q, last_d;
    logic             grant;
    logic             accept;
    logic             take;

    rr_arb2 u_rr_arb2 (
        .req   ({in1_valid, in0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    assign accept    = (state_q == EMPTY) || out_ready;
    assign in0_ready = accept && !grant;
    assign in1_ready = accept && grant;
    assign take      = accept && (grant ? in1_valid : in0_valid);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (take) begin
            data_d  = grant ? in1_data : in0_data;
            src_d   = grant;
            last_d  = grant;
            state_d = FULL;
        end else if (out_ready) begin
            // Drained with nothing to reload; data/src keep their stale value.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: doc/stream_arb2to1.md
STREAM_ARB2TO1 -- requirements
Module: stream_arb2to1

Interface
REQ-001: Parameter WIDTH, default 8, sets the payload width of each input and of the output.
REQ-002: clk  input  1  single clock for all state; rising-edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: in0_valid  input  1  source 0 has a payload on in0_data.
REQ-005: in0_data  input  WIDTH  source 0 payload.
REQ-006: in0_ready  output  1  source 0 payload accepted when in0_valid && in0_ready at clk rise.
REQ-007: in1_valid, in1_data, in1_ready  input/input/output  1/WIDTH/1  source 1, same semantics as source 0.
REQ-008: out_valid  output  1  output register holds a payload.
REQ-009: out_data  output  WIDTH  selected payload; this feeds the data pair of the downstream 2:1 mux.
REQ-010: out_src  output  1  index of the source that supplied out_data; this drives the downstream mux sel.
REQ-011: out_ready  input  1  consumer takes the payload when out_valid && out_ready at clk rise.

Function
REQ-012: The block SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013: The accept condition SHALL be accept = (state==EMPTY) || out_ready; this path is combinational from out_ready.
REQ-014: in0_ready SHALL equal accept && grant==0, and in1_ready SHALL equal accept && grant==1.
REQ-015: With exactly one input valid, grant SHALL select that input.
REQ-016: With both inputs valid, grant SHALL select the input opposite to last_grant (round-robin).
REQ-017: With neither input valid, no input SHALL be accepted.
REQ-018: On a clock with accept and a valid granted input, out_data/out_src SHALL load that payload/index, last_grant SHALL update to that index, and state SHALL go to FULL.
REQ-019: Latency SHALL be 1 cycle from input handshake to out_valid.
REQ-020: In FULL with out_ready=0, out_data, out_src and out_valid SHALL hold stable, both in_ready SHALL be 0, and last_grant SHALL not change.
REQ-021: In FULL with out_ready=1 and a valid granted input, the output SHALL reload in the same cycle, giving a sustained throughput of 1 payload/cycle.
REQ-022: In FULL with out_ready=1 and no valid input, state SHALL go to EMPTY.
REQ-023: The grant decision SHALL not depend on whether the granted input's handshake completes; an input that drops valid before acceptance SHALL lose its grant on the next evaluation.
REQ-024: Under continuous dual contention, outputs SHALL alternate 0,1,0,1…; neither source SHALL wait more than one accepted transfer.
REQ-025: Payload bits SHALL pass unmodified; there is no width conversion.

Reset
REQ-026: While rst_n=0, the block SHALL immediately set state=EMPTY, out_valid=0, out_data=0, out_src=0, and last_grant=1, so that source 0 wins the first contention.
REQ-027: Reset asserted mid-transfer SHALL discard the held payload with no partial output.
REQ-028: in_ready SHALL be combinational; after reset release, accept=1.

Structure
REQ-029: A shared package stream_arb_pkg SHALL hold the FSM state typedef (EMPTY, FULL) and the default WIDTH constant.
REQ-030: The round-robin decision SHALL live in one sub-module, rr_arb2, with inputs req[1:0] and last and output grant; it is purely combinational.
REQ-031: last_grant and the output register SHALL reside in the top module.

Verification
REQ-032: Reset, then in0_valid=1 with in0_data=8'hA5, out_ready=1 -> in0_ready=1; the next cycle out_valid=1, out_data=8'hA5, out_src=0.
REQ-033: Both inputs valid every cycle with data 8'h11/8'h22 and out_ready=1 -> out_src sequence 0,1,0,1 and data 11,22,11,22, one payload per cycle.
REQ-034: FULL with out_data=8'h3C and out_ready=0 for 5 cycles while both inputs are valid -> out_data stays 3C, both in_ready=0, and the order is unchanged once out_ready rises.
REQ-035: Only in1 valid for 3 cycles with 8'h01..8'h03 -> all outputs have out_src=1 and the values arrive in order; the following contention grants in0.
REQ-036: rst_n pulsed low mid-stream while FULL -> out_valid=0 that same cycle, and the first contention after release is granted to in0.
REQ-037: A random valid/ready/data run of 1000 cycles SHALL show no loss or duplication, with out_data===(out_src ? in1_data : in0_data) as captured at acceptance.
